// File: rtl/countdown_timer_pkg.sv
// Shared types and defaults for the loadable seconds countdown timer.
package countdown_timer_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PAUSE,
        S_EXPIRED
    } timer_state_t;

    localparam int unsigned DEFAULT_MAX_1Hz_div_count = 24999999;

endpackage

// File: rtl/tick_divider.sv
// Clock divider producing a one-cycle tick every MAX_1Hz_div_count+1 enabled clocks.
module tick_divider
    import countdown_timer_pkg::*;
#(
    parameter int unsigned MAX_1Hz_div_count = DEFAULT_MAX_1Hz_div_count,
    parameter int unsigned DIV_WIDTH         = 25
) (
    input  logic CLOCK_50_I,
    input  logic resetn,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam logic [DIV_WIDTH-1:0] TERMINAL = DIV_WIDTH'(MAX_1Hz_div_count);

    logic [DIV_WIDTH-1:0] div_q;
    logic [DIV_WIDTH-1:0] div_d;

    // Holding while disabled keeps the fractional second across a pause.
    always_comb begin
        div_d = div_q;
        if (clear) begin
            div_d = '0;
        end else if (enable) begin
            if (div_q == TERMINAL) begin
                div_d = '0;
            end else begin
                div_d = div_q + DIV_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    assign tick = enable && (div_q == TERMINAL);

endmodule

// File: rtl/countdown_timer.sv
// Loadable 8-bit seconds countdown timer with run/pause control and expiry flag.
module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter int unsigned MAX_1Hz_div_count = DEFAULT_MAX_1Hz_div_count,
    parameter int unsigned DIV_WIDTH         = 25
) (
    input  logic       CLOCK_50_I,
    input  logic       resetn,
    input  logic [7:0] load_value_i,
    input  logic       load_i,
    input  logic       start_stop_i,
    output logic [7:0] count_o,
    output logic       running_o,
    output logic       expired_o,
    output logic       tick_o
);

    timer_state_t state_q;
    timer_state_t state_d;
    logic [7:0]   count_q;
    logic [7:0]   count_d;
    logic         tick;
    logic         final_tick;
    logic         div_clear;

    assign final_tick = tick && (count_q == 8'd1);
    assign div_clear  = load_i || final_tick;

    tick_divider #(
        .MAX_1Hz_div_count(MAX_1Hz_div_count),
        .DIV_WIDTH        (DIV_WIDTH)
    ) u_tick_divider (
        .CLOCK_50_I(CLOCK_50_I),
        .resetn    (resetn),
        .enable    (state_q == S_RUN),
        .clear     (div_clear),
        .tick      (tick)
    );

    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            count_q <= 8'd0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Load has priority over both start/stop and a coincident tick.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        if (load_i) begin
            state_d = S_IDLE;
            count_d = load_value_i;
        end else begin
            if (tick && (count_q != 8'd0)) begin
                count_d = count_q - 8'd1;
            end
            unique case (state_q)
                S_IDLE: begin
                    if (start_stop_i && (count_q != 8'd0)) begin
                        state_d = S_RUN;
                    end
                end
                S_RUN: begin
                    if (final_tick) begin
                        state_d = S_EXPIRED;
                    end else if (start_stop_i) begin
                        state_d = S_PAUSE;
                    end
                end
                S_PAUSE: begin
                    if (start_stop_i) begin
                        state_d = S_RUN;
                    end
                end
                S_EXPIRED: begin
                    state_d = S_EXPIRED;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        count_o   = count_q;
        running_o = (state_q == S_RUN);
        expired_o = (state_q == S_EXPIRED);
        tick_o    = tick;
    end

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer with a 4-clock tick period.
module tb_countdown_timer;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [7:0] load_value = 8'd0;
    logic       load = 1'b0;
    logic       start_stop = 1'b0;
    logic [7:0] count_o;
    logic       running_o;
    logic       expired_o;
    logic       tick_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      name;
        logic [7:0] count;
        logic       running;
        logic       expired;
        logic       tick;
    } snap_t;

    snap_t      snap_q[$];
    logic [7:0] tick_q[$];

    countdown_timer #(
        .MAX_1Hz_div_count(3),
        .DIV_WIDTH        (4)
    ) dut (
        .CLOCK_50_I  (clk),
        .resetn      (resetn),
        .load_value_i(load_value),
        .load_i      (load),
        .start_stop_i(start_stop),
        .count_o     (count_o),
        .running_o   (running_o),
        .expired_o   (expired_o),
        .tick_o      (tick_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    // Monitor: drains pending snapshots and matches every tick_o pulse against the tick queue.
    always @(negedge clk) begin : monitor
        snap_t s;
        while (snap_q.size() > 0) begin
            s = snap_q.pop_front();
            chk({s.name, ".count"},   {24'd0, count_o},   {24'd0, s.count});
            chk({s.name, ".running"}, {31'd0, running_o}, {31'd0, s.running});
            chk({s.name, ".expired"}, {31'd0, expired_o}, {31'd0, s.expired});
            chk({s.name, ".tick"},    {31'd0, tick_o},    {31'd0, s.tick});
        end
        if (tick_o !== 1'b0) begin
            if (tick_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_tick: tick_o=%b with count_o=%0d, required no tick",
                         tick_o, count_o);
            end else begin
                chk("tick_count", {24'd0, count_o}, {24'd0, tick_q.pop_front()});
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_load(input logic [7:0] v);
        load_value = v;
        load       = 1'b1;
        cyc();
        load       = 1'b0;
    endtask

    task automatic pulse_start();
        start_stop = 1'b1;
        cyc();
        start_stop = 1'b0;
    endtask

    task automatic expect_snap(input string name, input logic [7:0] c, input logic r,
                               input logic e, input logic t);
        snap_t s;
        s.name    = name;
        s.count   = c;
        s.running = r;
        s.expired = e;
        s.tick    = t;
        snap_q.push_back(s);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        // Reset asserted mid-run, in the cycle where a tick would be visible.
        repeat (2) cyc();
        resetn = 1'b1;
        cyc();
        expect_snap("por", 8'd0, 1'b0, 1'b0, 1'b0);
        pulse_load(8'd5);
        pulse_start();
        repeat (2) cyc();
        expect_snap("pre_reset", 8'd5, 1'b1, 1'b0, 1'b0);
        cyc();
        resetn = 1'b0;
        #1;
        expect_snap("async_reset", 8'd0, 1'b0, 1'b0, 1'b0);
        cyc();
        resetn = 1'b1;
        repeat (10) cyc();
        expect_snap("post_reset_idle", 8'd0, 1'b0, 1'b0, 1'b0);

        // Full countdown from 5 to expiry.
        pulse_load(8'd5);
        expect_snap("load5", 8'd5, 1'b0, 1'b0, 1'b0);
        for (int i = 5; i >= 1; i--) tick_q.push_back(8'(i));
        pulse_start();
        repeat (3) cyc();
        expect_snap("first_tick", 8'd5, 1'b1, 1'b0, 1'b1);
        cyc();
        expect_snap("after_first_tick", 8'd4, 1'b1, 1'b0, 1'b0);
        repeat (16) cyc();
        expect_snap("expired", 8'd0, 1'b0, 1'b1, 1'b0);
        repeat (20) cyc();
        expect_snap("expired_hold", 8'd0, 1'b0, 1'b1, 1'b0);
        pulse_start();
        expect_snap("expired_start_ignored", 8'd0, 1'b0, 1'b1, 1'b0);

        // Pause preserves the fractional second.
        pulse_load(8'd3);
        expect_snap("load3", 8'd3, 1'b0, 1'b0, 1'b0);
        tick_q.push_back(8'd3);
        pulse_start();
        repeat (4) cyc();
        expect_snap("run3_first", 8'd2, 1'b1, 1'b0, 1'b0);
        repeat (2) cyc();
        pulse_start();
        expect_snap("paused", 8'd2, 1'b0, 1'b0, 1'b0);
        repeat (10) cyc();
        expect_snap("pause_hold", 8'd2, 1'b0, 1'b0, 1'b0);
        tick_q.push_back(8'd2);
        pulse_start();
        expect_snap("resume_tick", 8'd2, 1'b1, 1'b0, 1'b1);
        cyc();
        expect_snap("after_resume", 8'd1, 1'b1, 1'b0, 1'b0);
        pulse_load(8'd1);
        expect_snap("abort_load1", 8'd1, 1'b0, 1'b0, 1'b0);

        // Load and start in the same cycle: load wins.
        load_value = 8'd9;
        load       = 1'b1;
        start_stop = 1'b1;
        cyc();
        load       = 1'b0;
        start_stop = 1'b0;
        expect_snap("load_start", 8'd9, 1'b0, 1'b0, 1'b0);
        repeat (6) cyc();
        expect_snap("load_start_hold", 8'd9, 1'b0, 1'b0, 1'b0);

        // Zero load: start ignored.
        pulse_load(8'd0);
        expect_snap("load0", 8'd0, 1'b0, 1'b0, 1'b0);
        pulse_start();
        repeat (5) cyc();
        expect_snap("zero_start", 8'd0, 1'b0, 1'b0, 1'b0);

        // Abort while running, restart from a cleared divider.
        pulse_load(8'd7);
        tick_q.push_back(8'd7);
        tick_q.push_back(8'd6);
        pulse_start();
        repeat (8) cyc();
        expect_snap("run7_two_ticks", 8'd5, 1'b1, 1'b0, 1'b0);
        pulse_load(8'd2);
        expect_snap("abort_load2", 8'd2, 1'b0, 1'b0, 1'b0);
        tick_q.push_back(8'd2);
        pulse_start();
        repeat (3) cyc();
        expect_snap("restart_tick", 8'd2, 1'b1, 1'b0, 1'b1);
        cyc();
        expect_snap("restart_after", 8'd1, 1'b1, 1'b0, 1'b0);

        // Load coincident with the final tick: no decrement, no expiry.
        tick_q.push_back(8'd1);
        repeat (3) cyc();
        expect_snap("final_tick_pending", 8'd1, 1'b1, 1'b0, 1'b1);
        pulse_load(8'd4);
        expect_snap("load_beats_tick", 8'd4, 1'b0, 1'b0, 1'b0);

        // Pause coincident with a tick: decrement happens and divider wraps.
        tick_q.push_back(8'd4);
        pulse_start();
        repeat (3) cyc();
        pulse_start();
        expect_snap("pause_on_tick", 8'd3, 1'b0, 1'b0, 1'b0);
        tick_q.push_back(8'd3);
        pulse_start();
        repeat (2) cyc();
        expect_snap("resume_wrapped", 8'd3, 1'b1, 1'b0, 1'b0);
        cyc();
        expect_snap("resume_wrapped_tick", 8'd3, 1'b1, 1'b0, 1'b1);
        pulse_load(8'd0);
        expect_snap("final_load0", 8'd0, 1'b0, 1'b0, 1'b0);

        cyc();
        @(negedge clk);
        #1;
        chk("tick_queue_drained", tick_q.size(), 0);
        chk("snap_queue_drained", snap_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
